vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Owns the single port of the framebuffer RAM and shares it between display scanout and
//  processor pixel writes. Sits between the VGA timing generator (x/y/active) and the RAM.
//  Scanout has absolute priority; writes are queued and drained in free slots.
//  Free slots are non-fetch pixels and all blanking. Returns the palette index per pixel.
// PARAMETERS
//  FB_W        320    framebuffer width in stored pixels
//  FB_H        256    framebuffer height in stored pixels
//  SCALE_LOG2  2      log2 of screen pixels per stored pixel (same factor in x and y)
//  ADDR_W      17     RAM address width; must satisfy 2**ADDR_W >= FB_W*FB_H
//  DATA_W      8      pixel data width
//  WQ_DEPTH    4      write queue depth (power of 2, >= 2)
// PORTS
//  pixel_clk  in   1       pixel clock; all logic on rising edge
//  reset      in   1       synchronous, active-high reset
//  active_in  in   1       timing generator: x_in/y_in are inside the visible area
//  x_in       in   12      current screen column
//  y_in       in   12      current screen row
//  wr_valid   in   1       write request valid
//  wr_ready   out  1       write queue can accept (= not full)
//  wr_addr    in   ADDR_W  linear framebuffer address of write
//  wr_data    in   DATA_W  pixel value to write
//  mem_addr   out  ADDR_W  RAM address (registered)
//  mem_we     out  1       RAM write enable (registered)
//  mem_wdata  out  DATA_W  RAM write data (registered)
//  mem_rdata  in   DATA_W  RAM read data; valid the cycle after mem_addr
//  pix_data   out  DATA_W  pixel value for coordinates presented 2 cycles earlier
//  pix_valid  out  1       active_in delayed 2 cycles
//  wr_err     out  1       sticky: an out-of-range write was discarded
// BEHAVIOUR
//  Reset: queue flushed; mem_addr=0, mem_we=0, mem_wdata=0, pix_data=0, pix_valid=0,
//   wr_err=0. wr_ready=1 from the first cycle after reset deasserts.
//   Reset mid-operation drops queued writes and any in-flight read.
//  Fetch condition (cycle t): active_in && x_in[SCALE_LOG2-1:0]==0 && col<FB_W && row<FB_H.
//   col = x_in>>SCALE_LOG2, row = y_in>>SCALE_LOG2.
//   Fetch address = row*FB_W + col, exact in ADDR_W bits. Multiplier or incremental
//   row-base register are both allowed.
//  Slot FSM, evaluated every cycle:
//   READ  - fetch condition true: cycle t+1 mem_addr=fetch addr, mem_we=0. Never stalled.
//   WRITE - fetch false, queue non-empty: pop head. If head addr < FB_W*FB_H, cycle t+1
//           mem_addr/mem_wdata=entry and mem_we=1. Otherwise mem_we=0 and wr_err<=1.
//   IDLE  - otherwise: mem_we=0 at t+1; mem_addr holds its last value.
//  Queue: FIFO, WQ_DEPTH entries; push when wr_valid && wr_ready.
//   Entry pushed at edge t is poppable no earlier than cycle t+1.
//   Push+pop in the same cycle is legal at any occupancy below full.
//   wr_ready = !full, combinational from occupancy only, never from wr_valid.
//   Writes leave the queue strictly in acceptance order.
//  Pixel output:
//   - READ at t: pix_data <= mem_rdata at edge ending cycle t+1; valid in cycle t+2.
//   - Held unchanged for the following 2**SCALE_LOG2-1 pixels (horizontal replication).
//   - Becomes 0 when pix_valid=0 or when the coordinates were outside FB_W/FB_H.
//  pix_valid(t+2) = active_in(t). The integrator delays sync by 2 cycles to match.
//  Writes are not forwarded to scanout; a pixel written and read in the same frame may show
//   either value.
// TESTING
//  1 Reset mid-drain: 3 writes queued, active_in=0, reset 1 cycle
//    -> no mem_we after reset; wr_ready=1; queue empty.
//  2 Blanking writes: active_in=0; accept (5,0xAA) at cycle 0, (6,0x55) at cycle 1
//    -> mem_we=1 addr 5 data AA at cycle 2; addr 6 data 55 at cycle 3.
//  3 Contention: y=0, x=0..7 active, queue full (4) -> mem_addr 0 and 1 (reads) at x=0,4;
//    4 writes occupy the other slots; wr_ready rises the cycle after first pop.
//  4 Readback: RAM[321]=0x3C, sweep x=4..7 at y=4 -> pix_data=0x3C, pix_valid=1
//    for 4 cycles starting 2 cycles after x=4.
//  5 Range: write addr 81920 -> no mem_we; wr_err=1 and stays 1 until reset.
//  6 Full: SCALE_LOG2=0, active line, 5 writes offered -> 4 accepted, wr_ready=0, 5th held;
//    on blanking, all 5 drain in order.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Processor-side pixel write channel into the framebuffer arbiter.
// The master drives write requests; the slave (arbiter) returns ready.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM port arbiter: scanout reads take every fetch pixel, queued
// processor writes drain in all remaining slots, and the fetched palette index
// is replicated across each group of screen pixels.
//
// slot state | meaning (type of the RAM access issued last cycle)
// -----------+-----------------------------------------------------------
// SLOT_IDLE  | no access; mem_we low, mem_addr holding its last value
// SLOT_READ  | scanout fetch; mem_rdata carries the pixel this cycle
// SLOT_WRITE | queue head popped (written if in range, else discarded)
module vga_fb_arbiter #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 256,
    parameter int SCALE_LOG2 = 2,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int WQ_DEPTH   = 4
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              active_in,
    input  logic [11:0]       x_in,
    input  logic [11:0]       y_in,
    vga_fb_arbiter_if.slave   wr_if,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              wr_err
);

    localparam int          PTR_W   = $clog2(WQ_DEPTH);
    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam logic [11:0] SUB_MASK = 12'((1 << SCALE_LOG2) - 1);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_WRITE
    } slot_t;

    slot_t slot_q, slot_d;

    logic [11:0]       col, row;
    logic              in_range, fetch;
    logic [ADDR_W-1:0] fetch_addr;

    // Write queue: pointers carry one extra wrap bit to tell full from empty.
    logic [ADDR_W-1:0] q_addr_q [WQ_DEPTH];
    logic [DATA_W-1:0] q_data_q [WQ_DEPTH];
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic              q_empty, q_full, push;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              head_ok;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wr_err_q, wr_err_d;

    // Scanout pipeline: stage 1 aligns timing info with the RAM read cycle.
    logic              act_d1_q, act_d1_d;
    logic              rng_d1_q, rng_d1_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;

    // Decode screen coordinates into a stored-pixel fetch request.
    always_comb begin
        col        = x_in >> SCALE_LOG2;
        row        = y_in >> SCALE_LOG2;
        in_range   = (32'(col) < 32'(FB_W)) && (32'(row) < 32'(FB_H));
        fetch      = active_in && ((x_in & SUB_MASK) == 12'd0) && in_range;
        fetch_addr = ADDR_W'(32'(row) * 32'(FB_W) + 32'(col));
    end

    // Queue status and head entry; ready depends on occupancy alone.
    always_comb begin
        q_empty   = (rd_ptr_q == wr_ptr_q);
        q_full    = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) &&
                    (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]);
        push      = wr_if.wr_valid && !q_full;
        head_addr = q_addr_q[rd_ptr_q[PTR_W-1:0]];
        head_data = q_data_q[rd_ptr_q[PTR_W-1:0]];
        head_ok   = 32'(head_addr) < FB_SIZE;
    end

    assign wr_if.wr_ready = !q_full;

    // Slot selection: fetch always wins, otherwise pop the queue head.
    always_comb begin
        slot_d      = SLOT_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_err_d    = wr_err_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (fetch) begin
            slot_d     = SLOT_READ;
            mem_addr_d = fetch_addr;
        end else if (!q_empty) begin
            slot_d   = SLOT_WRITE;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (head_ok) begin
                mem_addr_d  = head_addr;
                mem_wdata_d = head_data;
                mem_we_d    = 1'b1;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Pixel output: capture on read, hold across the replicated group, blank otherwise.
    always_comb begin
        act_d1_d    = active_in;
        rng_d1_d    = in_range;
        pix_valid_d = act_d1_q;
        pix_data_d  = pix_data_q;
        if (slot_q == SLOT_READ) begin
            pix_data_d = mem_rdata;
        end else if (!(act_d1_q && rng_d1_q)) begin
            pix_data_d = '0;
        end
    end

    // Queue storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge pixel_clk) begin
        if (push) begin
            q_addr_q[wr_ptr_q[PTR_W-1:0]] <= wr_if.wr_addr;
            q_data_q[wr_ptr_q[PTR_W-1:0]] <= wr_if.wr_data;
        end
    end

    // State, RAM port and pixel pipeline registers.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            slot_q      <= SLOT_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_err_q    <= 1'b0;
            act_d1_q    <= 1'b0;
            rng_d1_q    <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_err_q    <= wr_err_d;
            act_d1_q    <= act_d1_d;
            rng_d1_q    <= rng_d1_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_err    = wr_err_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: one instance at the default 4x scale with a
// behavioural RAM, one at 1x scale where every visible pixel is a fetch.
module tb_vga_fb_arbiter;

    logic        clk;
    logic        reset;
    logic        active_in;
    logic [11:0] x_in;
    logic [11:0] y_in;

    logic [16:0] mem_addr,  mem_addr0;
    logic        mem_we,    mem_we0;
    logic [7:0]  mem_wdata, mem_wdata0;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_data,  pix_data0;
    logic        pix_valid, pix_valid0;
    logic        wr_err,    wr_err0;

    logic [7:0]  ram [0:(1<<17)-1];

    int errors = 0;
    int checks = 0;

    vga_fb_arbiter_if #(.ADDR_W(17), .DATA_W(8)) wif ();
    vga_fb_arbiter_if #(.ADDR_W(17), .DATA_W(8)) wif0 ();

    vga_fb_arbiter dut (
        .pixel_clk (clk),
        .reset     (reset),
        .active_in (active_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .wr_if     (wif),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .wr_err    (wr_err)
    );

    vga_fb_arbiter #(.SCALE_LOG2(0)) dut0 (
        .pixel_clk (clk),
        .reset     (reset),
        .active_in (active_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .wr_if     (wif0),
        .mem_addr  (mem_addr0),
        .mem_we    (mem_we0),
        .mem_wdata (mem_wdata0),
        .mem_rdata (8'h00),
        .pix_data  (pix_data0),
        .pix_valid (pix_valid0),
        .wr_err    (wr_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: combinational read of the registered address, write on the edge.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected RAM port per cycle during the contention sweep (x = 0..7).
    logic        t3_we   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [16:0] t3_addr [8] = '{17'd0, 17'd50, 17'd51, 17'd52, 17'd1, 17'd53, 17'd53, 17'd53};
    logic [7:0]  t3_data [8] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'h00, 8'hA3, 8'h00, 8'h00};

    initial begin
        reset = 1'b1;
        active_in = 1'b0;
        x_in = '0;
        y_in = '0;
        wif.wr_valid = 1'b0;  wif.wr_addr = '0;  wif.wr_data = '0;
        wif0.wr_valid = 1'b0; wif0.wr_addr = '0; wif0.wr_data = '0;
        repeat (2) tick();

        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_pix_data",  32'(pix_data),  32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_wr_err",    32'(wr_err),    32'd0);
        check("rst_pix_data0", 32'(pix_data0), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_wr_ready",  32'(wif.wr_ready),  32'd1);
        check("rst_wr_ready0", 32'(wif0.wr_ready), 32'd1);

        // Reset mid-drain: fill three entries on a fetch-every-pixel line, then reset.
        active_in = 1'b1; y_in = 12'd0; x_in = 12'd20;
        wif0.wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wif0.wr_addr = 17'(200 + i);
            wif0.wr_data = 8'(8'h30 + i);
            tick();
        end
        wif0.wr_valid = 1'b0;
        check("t1_no_pop_on_line", 32'(mem_we0), 32'd0);
        active_in = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t1_we_in_reset",  32'(mem_we0), 32'd0);
        tick();
        check("t1_we_after_rst", 32'(mem_we0), 32'd0);
        check("t1_ready",        32'(wif0.wr_ready), 32'd1);
        tick();
        check("t1_we_later",     32'(mem_we0), 32'd0);

        // Blanking writes drain one cycle after acceptance.
        wif.wr_valid = 1'b1; wif.wr_addr = 17'd5; wif.wr_data = 8'hAA;
        tick();
        wif.wr_addr = 17'd6; wif.wr_data = 8'h55;
        tick();
        wif.wr_valid = 1'b0;
        check("t2_we_a",   32'(mem_we),    32'd1);
        check("t2_addr_a", 32'(mem_addr),  32'd5);
        check("t2_data_a", 32'(mem_wdata), 32'hAA);
        tick();
        check("t2_we_b",   32'(mem_we),    32'd1);
        check("t2_addr_b", 32'(mem_addr),  32'd6);
        check("t2_data_b", 32'(mem_wdata), 32'h55);
        tick();
        check("t2_idle_we",   32'(mem_we),   32'd0);
        check("t2_idle_addr", 32'(mem_addr), 32'd6);

        // Contention: reads at x=0 and x=4, writes fill the other slots.
        active_in = 1'b1; y_in = 12'd0;
        for (int x = 0; x < 8; x++) begin
            x_in = 12'(x);
            wif.wr_valid = (x < 4);
            wif.wr_addr  = 17'(50 + x);
            wif.wr_data  = 8'(8'hA0 + x);
            tick();
            check($sformatf("t3_we_x%0d", x),   32'(mem_we),   32'(t3_we[x]));
            check($sformatf("t3_addr_x%0d", x), 32'(mem_addr), 32'(t3_addr[x]));
            if (t3_we[x]) check($sformatf("t3_data_x%0d", x), 32'(mem_wdata), 32'(t3_data[x]));
        end
        wif.wr_valid = 1'b0;
        active_in = 1'b0;

        // Readback: store 0x3C at 321 during blanking, then scan row 1 column 1.
        wif.wr_valid = 1'b1; wif.wr_addr = 17'd321; wif.wr_data = 8'h3C;
        tick();
        wif.wr_valid = 1'b0;
        tick();
        check("t4_store_we",   32'(mem_we),   32'd1);
        check("t4_store_addr", 32'(mem_addr), 32'd321);
        tick();
        active_in = 1'b1; y_in = 12'd4; x_in = 12'd4;
        tick();
        check("t4_rd_addr", 32'(mem_addr),  32'd321);
        check("t4_rd_we",   32'(mem_we),    32'd0);
        check("t4_pv_pre",  32'(pix_valid), 32'd0);
        for (int x = 5; x < 8; x++) begin
            x_in = 12'(x);
            tick();
            check($sformatf("t4_pd_%0d", x - 3), 32'(pix_data),  32'h3C);
            check($sformatf("t4_pv_%0d", x - 3), 32'(pix_valid), 32'd1);
        end
        active_in = 1'b0;
        tick();
        check("t4_pd_5", 32'(pix_data),  32'h3C);
        check("t4_pv_5", 32'(pix_valid), 32'd1);
        tick();
        check("t4_pd_end", 32'(pix_data),  32'd0);
        check("t4_pv_end", 32'(pix_valid), 32'd0);

        // Last column fetches; one column further is outside the framebuffer.
        active_in = 1'b1; y_in = 12'd4; x_in = 12'd1276;
        tick();
        check("t4_lastcol_addr", 32'(mem_addr), 32'd639);
        x_in = 12'd1280;
        tick();
        check("t4_lastcol_pv", 32'(pix_valid), 32'd1);
        active_in = 1'b0;
        tick();
        check("t4_oor_pv", 32'(pix_valid), 32'd1);
        check("t4_oor_pd", 32'(pix_data),  32'd0);
        tick();
        check("t4_oor_pv_end", 32'(pix_valid), 32'd0);

        // Full queue at 1x scale: four accepted, fifth held, all five drain in order.
        active_in = 1'b1; y_in = 12'd0; x_in = 12'd10;
        wif0.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wif0.wr_addr = 17'(1000 + i);
            wif0.wr_data = 8'(8'h10 + i);
            check($sformatf("t6_ready_%0d", i), 32'(wif0.wr_ready), 32'd1);
            tick();
        end
        wif0.wr_addr = 17'd1004; wif0.wr_data = 8'h14;
        check("t6_full",      32'(wif0.wr_ready), 32'd0);
        check("t6_read_we",   32'(mem_we0),       32'd0);
        check("t6_read_addr", 32'(mem_addr0),     32'd10);
        check("t6_pv0",       32'(pix_valid0),    32'd1);
        tick();
        check("t6_held", 32'(wif0.wr_ready), 32'd0);
        active_in = 1'b0;
        tick();
        check("t6_drain_we_0",   32'(mem_we0),    32'd1);
        check("t6_drain_addr_0", 32'(mem_addr0),  32'd1000);
        check("t6_drain_data_0", 32'(mem_wdata0), 32'h10);
        check("t6_ready_after",  32'(wif0.wr_ready), 32'd1);
        tick();
        wif0.wr_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            check($sformatf("t6_drain_we_%0d", k),   32'(mem_we0),    32'd1);
            check($sformatf("t6_drain_addr_%0d", k), 32'(mem_addr0),  32'(1000 + k));
            check($sformatf("t6_drain_data_%0d", k), 32'(mem_wdata0), 32'(8'h10 + k));
            tick();
        end
        check("t6_drain_done", 32'(mem_we0), 32'd0);

        // Out-of-range write is dropped and latches the error flag.
        wif.wr_valid = 1'b1; wif.wr_addr = 17'd81920; wif.wr_data = 8'h77;
        tick();
        wif.wr_valid = 1'b0;
        tick();
        check("t5_drop_we", 32'(mem_we), 32'd0);
        check("t5_err_set", 32'(wr_err), 32'd1);
        wif.wr_valid = 1'b1; wif.wr_addr = 17'd81919; wif.wr_data = 8'h12;
        tick();
        wif.wr_valid = 1'b0;
        tick();
        check("t5_last_we",   32'(mem_we),    32'd1);
        check("t5_last_addr", 32'(mem_addr),  32'd81919);
        check("t5_last_data", 32'(mem_wdata), 32'h12);
        check("t5_err_sticky", 32'(wr_err),   32'd1);

        // Rows past the framebuffer are free slots even while active.
        active_in = 1'b1; y_in = 12'd1024; x_in = 12'd0;
        wif.wr_valid = 1'b1; wif.wr_addr = 17'd700; wif.wr_data = 8'h66;
        tick();
        wif.wr_valid = 1'b0;
        tick();
        check("t5_row_we",   32'(mem_we),    32'd1);
        check("t5_row_addr", 32'(mem_addr),  32'd700);
        check("t5_row_pv",   32'(pix_valid), 32'd1);
        check("t5_row_pd",   32'(pix_data),  32'd0);
        active_in = 1'b0;
        tick();
        check("t5_err_still", 32'(wr_err), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_err_cleared", 32'(wr_err),  32'd0);
        check("t5_err0_clear",  32'(wr_err0), 32'd0);
        tick();
        check("t5_err_after",   32'(wr_err), 32'd0);
        check("t5_we_after",    32'(mem_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
